// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the multi-cycle adder/subtractor.
//   state_e     - FSM state encoding (idle / run / done)
//   OP_ADD/SUB  - encoding of the S (operation select) input
//   calc_nchunk - number of CHUNK-wide slices in a WIDTH-bit operand
//   calc_idx_w  - width of the chunk index counter (at least one bit)
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned calc_nchunk(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: purely combinational W-bit ripple of full-adder cells.
//   a, b  in  W  chunk operands
//   cin   in  1  carry into bit 0
//   sum   out W  chunk sum
//   cout  out 1  carry out of the top bit
//   c_msb out 1  carry into the top bit (needed for signed overflow)
module addsub_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  always_comb begin
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout  = c[W];
    c_msb = c[W-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor, CHUNK bits per cycle through a
// registered carry, with valid/ready handshakes on both sides.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only when idle)
//   A, B, S             operands and operation (S: 0 = A+B, 1 = A-B)
//   SAT                 saturate on signed overflow (only when ADDSUB_SAT_EN is defined)
//   out_valid/out_ready result handshake (out_valid high only when done)
//   ANSWER              result, modulo 2^WIDTH
//   COUT, OVF, ZERO     carry out of MSB, signed overflow, result-is-zero
// Build option: define ADDSUB_SAT_EN to add the SAT port and clamping on overflow.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
`ifdef ADDSUB_SAT_EN
  input  logic             SAT,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ANSWER,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = calc_idx_w(NCHUNK);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;    // B already inverted for subtract
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
`ifdef ADDSUB_SAT_EN
  logic               sat_q, sat_d;
`endif

  logic [CHUNK-1:0]   a_chunk, b_chunk, sum_chunk;
  logic               chunk_cout, chunk_c_msb;
  logic [WIDTH-1:0]   res_wr, res_fin;
  logic               last, ovf_now;

  // Select the active chunk of each operand and merge the new sum into the result.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    res_wr  = res_q;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk                  = a_q[i*CHUNK +: CHUNK];
        b_chunk                  = b_q[i*CHUNK +: CHUNK];
        res_wr[i*CHUNK +: CHUNK] = sum_chunk;
      end
    end
  end

  addsub_chunk #(
    .W(CHUNK)
  ) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (sum_chunk),
    .cout (chunk_cout),
    .c_msb(chunk_c_msb)
  );

  assign last    = (idx_q == IDX_W'(NCHUNK - 1));
  assign ovf_now = chunk_c_msb ^ chunk_cout;

  // Sign of the overflow follows the MSB of A: both overflow directions need A and B' to agree.
  always_comb begin
    res_fin = res_wr;
`ifdef ADDSUB_SAT_EN
    if (sat_q && ovf_now) begin
      res_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`ifdef ADDSUB_SAT_EN
    sat_d   = sat_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{S == OP_SUB}};
          carry_d = (S == OP_SUB);
          idx_d   = '0;
`ifdef ADDSUB_SAT_EN
          sat_d   = SAT;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = res_wr;
        carry_d = chunk_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last) begin
          res_d   = res_fin;
          cout_d  = chunk_cout;
          ovf_d   = ovf_now;
          zero_d  = (res_fin == '0);
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`ifdef ADDSUB_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign ANSWER    = res_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed and random checks of addsub_seq (WIDTH=16, CHUNK=4) against an
// arithmetic reference model. Define ADDSUB_SAT_EN to also exercise saturation.
module tb_addsub_seq;
  import addsub_pkg::*;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b1;
  logic              s         = 1'b0;
  logic              sat       = 1'b0;
  logic [WIDTH-1:0]  a         = '0;
  logic [WIDTH-1:0]  b         = '0;
  logic              in_ready, out_valid, cout, ovf, zero;
  logic [WIDTH-1:0]  answer;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_seq #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .S        (s),
`ifdef ADDSUB_SAT_EN
    .SAT      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ANSWER   (answer),
    .COUT     (cout),
    .OVF      (ovf),
    .ZERO     (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                input logic msat, output logic [15:0] ans, output logic co,
                                output logic ov, output logic z);
    logic [16:0] tot;
    tot = {1'b0, ma} + {1'b0, (ms ? ~mb : mb)} + 17'(ms);
    ans = tot[15:0];
    co  = tot[16];
    if (ms) ov = (ma[15] != mb[15]) && (ans[15] != ma[15]);
    else    ov = (ma[15] == mb[15]) && (ans[15] != ma[15]);
    if (msat && ov) ans = ma[15] ? 16'h8000 : 16'h7FFF;
    z = (ans == 16'h0000);
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                        input logic tsat, input int hold, output logic [15:0] got);
    logic [15:0] e_ans;
    logic        e_co, e_ov, e_z, eff_sat;
    int          n;
`ifdef ADDSUB_SAT_EN
    eff_sat = tsat;
`else
    eff_sat = 1'b0;
`endif
    model(ta, tb, ts, eff_sat, e_ans, e_co, e_ov, e_z);

    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);

    a = ta; b = tb; s = ts; sat = tsat; in_valid = 1'b1;
    out_ready = (hold == 0);
    tick();  // accept edge
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); sat = 1'($urandom);

    for (int k = 1; k <= int'(NCHUNK); k++) begin
      tick();
      chk($sformatf("latency_k%0d {in_ready,out_valid}", k), 32'({in_ready, out_valid}),
          32'({1'b0, (k == int'(NCHUNK))}));
    end
    chk($sformatf("result %h %s %h {ans,cout,ovf,zero}", ta, ts ? "-" : "+", tb),
        32'({answer, cout, ovf, zero}), 32'({e_ans, e_co, e_ov, e_z}));
    got = answer;

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      tick();
      chk($sformatf("hold_%0d {in_ready,out_valid,ans,flags}", h),
          32'({in_ready, out_valid, answer, cout, ovf, zero}),
          32'({1'b0, 1'b1, e_ans, e_co, e_ov, e_z}));
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("return_idle {in_ready,out_valid}", 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    logic [15:0] got;
    logic        seen_valid;

    #2 rst_n = 1'b0;
    #1;
    chk("reset {in_ready,out_valid,ans,cout,ovf,zero}",
        32'({in_ready, out_valid, answer, cout, ovf, zero}), 32'({1'b1, 1'b0, 16'h0, 3'b000}));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op(16'h1234, 16'h0FFF, OP_ADD, 1'b0, 0, got);
    chk("add_1234_0fff", 32'(got), 32'h2233);
    run_op(16'h0005, 16'h0007, OP_SUB, 1'b0, 0, got);
    chk("sub_5_7", 32'(got), 32'hFFFE);
    run_op(16'h1234, 16'h1234, OP_SUB, 1'b0, 0, got);
    chk("sub_equal_zero {ans,zero}", 32'({got, zero}), 32'({16'h0000, 1'b1}));
    run_op(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 0, got);
    chk("add_pos_ovf_wrap {ans,ovf}", 32'({got, ovf}), 32'({16'h8000, 1'b1}));
    run_op(16'h8000, 16'h0001, OP_SUB, 1'b0, 0, got);
    chk("sub_neg_ovf_wrap {ans,ovf,cout}", 32'({got, ovf, cout}), 32'({16'h7FFF, 2'b11}));
`ifdef ADDSUB_SAT_EN
    run_op(16'h7FFF, 16'h0001, OP_ADD, 1'b1, 0, got);
    chk("add_pos_ovf_sat {ans,ovf}", 32'({got, ovf}), 32'({16'h7FFF, 1'b1}));
    run_op(16'h8000, 16'h0001, OP_SUB, 1'b1, 0, got);
    chk("sub_neg_ovf_sat {ans,ovf}", 32'({got, ovf}), 32'({16'h8000, 1'b1}));
`endif

    // Backpressure: held in done for five cycles with inputs churning.
    run_op(16'hA5A5, 16'h1111, OP_ADD, 1'b0, 5, got);
    run_op(16'h0F0F, 16'hF0F0, OP_SUB, 1'b0, 1, got);

    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), got);
    end

    // Reset mid-run at idx = 2; previous result is non-zero so the clear is observable.
    run_op(16'h4321, 16'h1111, OP_ADD, 1'b0, 0, got);
    a = 16'h0003; b = 16'h0004; s = OP_ADD; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset {in_ready,out_valid,ans,cout,ovf,zero}",
        32'({in_ready, out_valid, answer, cout, ovf, zero}), 32'({1'b1, 1'b0, 16'h0, 3'b000}));
    tick();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    chk("no_valid_after_reset", 32'(seen_valid), 32'd0);
    run_op(16'h0001, 16'h0001, OP_ADD, 1'b0, 0, got);
    chk("add_after_reset", 32'(got), 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
